pwm_dac: RTL and testbench

PWM_DAC -- requirements
Module: pwm_dac

---
 rtl/pwm_dac.sv | 132 +++++++++++++
 tb/tb_pwm_dac.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pwm_dac.sv
// pwm_dac: converts signed wave-generator samples into a PWM bitstream.
// A free-running period counter of 2^W-1 cycles is compared against an
// offset-binary duty value that only changes at period boundaries.
// Optional feature: define PWM_OVERRUN_EN to add the sticky overrun_o flag,
// which marks a sample overwritten before it could be used.
module pwm_dac #(
  parameter int unsigned N_FRAC = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic signed [N_FRAC:0]   data_i,
  input  logic                     data_valid_strobe_i,
  output logic                     pwm_o,
  output logic                     period_strobe_o
`ifdef PWM_OVERRUN_EN
  ,
  output logic                     overrun_o
`endif
);

  localparam int unsigned W = N_FRAC + 1;
  localparam int unsigned P = (2 ** W) - 1;
  localparam logic [W-1:0] CNT_LAST = W'(P - 1);
  localparam logic [W-1:0] MIDSCALE = {1'b1, {N_FRAC{1'b0}}};

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] pending_q, pending_d;
  logic         pending_valid_q, pending_valid_d;
  logic [W-1:0] active_duty_q, active_duty_d;
  logic         pwm_q, pwm_d;
  logic         period_strobe_q, period_strobe_d;
`ifdef PWM_OVERRUN_EN
  logic         overrun_q, overrun_d;
`endif

  logic         cnt_wrap;
  logic [W-1:0] sample_duty;

  // Wrap detect and signed-to-offset-binary conversion of the incoming sample
  always_comb begin
    cnt_wrap    = (cnt_q == CNT_LAST);
    sample_duty = {~data_i[N_FRAC], data_i[N_FRAC-1:0]};
  end

  // Period counter: held at zero while disabled so counting restarts cleanly
  always_comb begin
    cnt_d = '0;
    if (enable_i && !cnt_wrap) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Sample handoff: pending buffer captures strobes, active duty swaps only on wrap
  always_comb begin
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    active_duty_d   = active_duty_q;
`ifdef PWM_OVERRUN_EN
    overrun_d       = overrun_q;
`endif
    if (!enable_i) begin
      // Disabled: drop any queued sample but keep the current duty
      pending_valid_d = 1'b0;
`ifdef PWM_OVERRUN_EN
      overrun_d       = 1'b0;
`endif
    end else begin
      if (data_valid_strobe_i) begin
        pending_d = sample_duty;
      end
      if (cnt_wrap) begin
        // A strobe landing on the wrap cycle bypasses the pending buffer
        pending_valid_d = 1'b0;
        if (data_valid_strobe_i) begin
          active_duty_d = sample_duty;
        end else if (pending_valid_q) begin
          active_duty_d = pending_q;
        end
      end else if (data_valid_strobe_i) begin
        pending_valid_d = 1'b1;
`ifdef PWM_OVERRUN_EN
        if (pending_valid_q) begin
          overrun_d = 1'b1;
        end
`endif
      end
    end
  end

  // Output bit and start-of-period marker, both one cycle behind the counter
  always_comb begin
    pwm_d           = 1'b0;
    period_strobe_d = 1'b0;
    if (enable_i) begin
      pwm_d           = (cnt_q < active_duty_q);
      period_strobe_d = (cnt_q == '0);
    end
  end

  // State registers with asynchronous reset to midscale duty
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q           <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      active_duty_q   <= MIDSCALE;
      pwm_q           <= 1'b0;
      period_strobe_q <= 1'b0;
`ifdef PWM_OVERRUN_EN
      overrun_q       <= 1'b0;
`endif
    end else begin
      cnt_q           <= cnt_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      active_duty_q   <= active_duty_d;
      pwm_q           <= pwm_d;
      period_strobe_q <= period_strobe_d;
`ifdef PWM_OVERRUN_EN
      overrun_q       <= overrun_d;
`endif
    end
  end

  assign pwm_o           = pwm_q;
  assign period_strobe_o = period_strobe_q;
`ifdef PWM_OVERRUN_EN
  assign overrun_o       = overrun_q;
`endif

endmodule

// File: tb/tb_pwm_dac.sv
// Directed bench for pwm_dac at the default width (W=8, period 255 cycles).
// Overrun checks are included when PWM_OVERRUN_EN is defined.
module tb_pwm_dac;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] data;
  logic       strobe;
  logic       pwm_o;
  logic       period_strobe_o;
`ifdef PWM_OVERRUN_EN
  logic       overrun_o;
`endif

  int checks = 0;
  int errors = 0;

  pwm_dac #(.N_FRAC(7)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .enable_i            (enable),
    .data_i              (data),
    .data_valid_strobe_i (strobe),
    .pwm_o               (pwm_o),
    .period_strobe_o     (period_strobe_o)
`ifdef PWM_OVERRUN_EN
    ,
    .overrun_o           (overrun_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs n cycles of a period assumed to start at cnt=0; strobes are applied on
  // the edges whose counter value equals s1/s2 (use -1 for none).
  task automatic run_steps(input int n, input int duty,
                           input int s1, input logic [7:0] d1,
                           input int s2, input logic [7:0] d2,
                           input string tag);
    int pm;
    int sm;
    pm = 0;
    sm = 0;
    for (int i = 0; i < n; i++) begin
      strobe = (i == s1) || (i == s2);
      data   = (i == s1) ? d1 : d2;
      step();
      if (pwm_o !== (i < duty)) pm++;
      if (period_strobe_o !== (i == 0)) sm++;
    end
    strobe = 1'b0;
    chk($sformatf("%s_pwm_bits_wrong", tag), pm, 0);
    chk($sformatf("%s_pstrobe_bits_wrong", tag), sm, 0);
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    strobe = 1'b0;
    data   = 8'h00;
    step();
    step();
    chk("reset_pwm", pwm_o, 0);
    chk("reset_pstrobe", period_strobe_o, 0);
`ifdef PWM_OVERRUN_EN
    chk("reset_overrun", overrun_o, 0);
`endif

    // Midscale after reset: 128 high of 255, strobe each period
    rst    = 1'b0;
    enable = 1'b1;
    run_steps(255, 128, -1, 8'h00, -1, 8'h00, "p1_mid");
    run_steps(255, 128, -1, 8'h00, -1, 8'h00, "p2_mid");

    // Full-scale positive mid-period, then full-scale negative
    run_steps(255, 128, 100, 8'h7F, -1, 8'h00, "p3_mid_strobe7f");
    run_steps(255, 255, 50, 8'h80, -1, 8'h00, "p4_full");
    // Strobe on the wrap cycle goes straight to the active duty
    run_steps(255, 0, 254, 8'h00, -1, 8'h00, "p5_zero");
`ifdef PWM_OVERRUN_EN
    chk("wrap_strobe_overrun", overrun_o, 0);
`endif
    // Two strobes in one period: newer wins
    run_steps(255, 128, 10, 8'h10, 20, 8'h20, "p6_mid_two");
`ifdef PWM_OVERRUN_EN
    chk("two_strobe_overrun", overrun_o, 1);
`endif
    // Wrap strobe overrides an already pending sample
    run_steps(255, 160, 30, 8'h40, 254, 8'h60, "p7_160");
`ifdef PWM_OVERRUN_EN
    chk("overrun_sticky", overrun_o, 1);
`endif

    // Disable mid-period with a sample pending
    run_steps(100, 224, 50, 8'h00, -1, 8'h00, "p8_224_partial");
    enable = 1'b0;
    step();
    chk("dis_pwm", pwm_o, 0);
    chk("dis_pstrobe", period_strobe_o, 0);
`ifdef PWM_OVERRUN_EN
    chk("dis_overrun", overrun_o, 0);
`endif
    strobe = 1'b1;
    data   = 8'h7F;
    step();
    strobe = 1'b0;
    step();
    step();
    chk("dis_hold_pwm", pwm_o, 0);
    chk("dis_hold_pstrobe", period_strobe_o, 0);

    // Re-enable: retained duty, pending dropped, disabled strobe ignored
    enable = 1'b1;
    run_steps(255, 224, -1, 8'h00, -1, 8'h00, "p9_reenable");
    run_steps(255, 224, -1, 8'h00, -1, 8'h00, "p10_no_pending");

    // Asynchronous reset while the output is high
    run_steps(10, 224, -1, 8'h00, -1, 8'h00, "p11_partial");
    chk("pre_reset_pwm", pwm_o, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_pwm", pwm_o, 0);
    step();
    step();
    rst = 1'b0;
    run_steps(255, 128, -1, 8'h00, -1, 8'h00, "p12_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
